// File: rtl/ysyx_23060332_wbu.sv
// Write-back stage: retires EXU/LSU results into the register file, waits for and extracts load data.
// Optional retire counter on commit_cnt is built only when YSYX_23060332_WBU_PERF_EN is defined.
module ysyx_23060332_wbu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic [2:0]        in_ld_type,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rready,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              reg_wen,
  output logic              commit,
  output logic              wb_busy,
  output logic [ADDR_W-1:0] wb_busy_rd,
  output logic              load_err,
  output logic [31:0]       commit_cnt
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [1:0]        addr_q, addr_d;
  logic [2:0]        ldt_q, ldt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, busy_rd_q, busy_rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              reg_wen_q, reg_wen_d, commit_q, commit_d;
  logic              busy_q, busy_d, err_q, err_d;

  logic              acc, pend, ld_bad;
  logic [DATA_W-1:0] byte_sh, half_sh, ld_data;

  assign in_ready   = (state_q == S_IDLE);
  assign mem_rready = (state_q == S_WAIT);
  assign acc        = in_valid && in_ready;
  assign pend       = wen_q && (rd_q != '0);

  assign byte_sh = mem_rdata >> {addr_q, 3'b000};
  assign half_sh = mem_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    ld_data = '0;
    ld_bad  = 1'b0;
    case (ldt_q)
      3'd0: ld_data = {{(DATA_W-8){byte_sh[7]}}, byte_sh[7:0]};
      3'd1: begin
        ld_data = {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]};
        ld_bad  = addr_q[0];
      end
      3'd2: begin
        ld_data = mem_rdata;
        ld_bad  = (addr_q != 2'b00);
      end
      3'd4: ld_data = {{(DATA_W-8){1'b0}}, byte_sh[7:0]};
      3'd5: begin
        ld_data = {{(DATA_W-16){1'b0}}, half_sh[15:0]};
        ld_bad  = addr_q[0];
      end
      default: ld_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    ldt_d     = ldt_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    reg_wen_d = 1'b0;
    commit_d  = 1'b0;
    busy_d    = 1'b0;
    busy_rd_d = '0;
    err_d     = err_q;
    if (state_q == S_IDLE) begin
      if (acc) begin
        rd_d   = in_rd;
        wen_d  = in_wen;
        addr_d = in_result[1:0];
        ldt_d  = in_ld_type;
        if (in_is_load) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          busy_d  = in_wen && (in_rd != '0);
        end else begin
          reg_wen_d = in_wen && (in_rd != '0);
          waddr_d   = in_rd;
          wdata_d   = in_result;
          commit_d  = 1'b1;
          busy_d    = reg_wen_d;
        end
        busy_rd_d = busy_d ? in_rd : '0;
      end
    end else begin
      if (mem_rvalid) begin
        // Bad loads still drain the response and retire, just without a write.
        state_d   = S_IDLE;
        commit_d  = 1'b1;
        reg_wen_d = pend && !ld_bad;
        waddr_d   = rd_q;
        wdata_d   = ld_bad ? '0 : ld_data;
        err_d     = err_q | ld_bad;
        busy_d    = reg_wen_d;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          busy_d = pend;
        end
      end
      busy_rd_d = busy_d ? rd_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      ldt_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      reg_wen_q <= 1'b0;
      commit_q  <= 1'b0;
      busy_q    <= 1'b0;
      busy_rd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      ldt_q     <= ldt_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      reg_wen_q <= reg_wen_d;
      commit_q  <= commit_d;
      busy_q    <= busy_d;
      busy_rd_q <= busy_rd_d;
      err_q     <= err_d;
    end
  end

  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign reg_wen    = reg_wen_q;
  assign commit     = commit_q;
  assign wb_busy    = busy_q;
  assign wb_busy_rd = busy_rd_q;
  assign load_err   = err_q;

`ifdef YSYX_23060332_WBU_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          perf_q <= '0;
    else if (commit_d) perf_q <= perf_q + 32'd1;
  end
  assign commit_cnt = perf_q;
`else
  assign commit_cnt = '0;
`endif

endmodule

// File: doc/ysyx_23060332_wbu.md
Name: ysyx_23060332_wbu

Overview:
Write-back stage of the single-issue RV32 NPC. Sits directly upstream of the 2R1W register file and drives its write port (waddr/wdata/reg_wen).
- Accepts completed instructions from EXU/LSU via valid/ready.
- For loads, waits for the memory read response, then extracts and extends the load data.
- Emits one commit pulse per retired instruction.
- Exports a pending-write indication for IDU hazard checks.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register index width
TIMEOUT, 255, max cycles in WAIT_MEM before the load is abandoned (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  EXU/LSU result valid
in_ready  out  1  WBU can accept
in_rd  in  ADDR_W  destination register
in_wen  in  1  instruction writes rd
in_result  in  DATA_W  ALU result (non-load) or load byte address (load)
in_is_load  in  1  instruction is a load
in_ld_type  in  3  load funct3: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu
mem_rvalid  in  1  memory read data valid
mem_rdata  in  DATA_W  word-aligned read data
mem_rready  out  1  WBU ready for read data
waddr  out  ADDR_W  regfile write address
wdata  out  DATA_W  regfile write data
reg_wen  out  1  regfile write enable
commit  out  1  one-cycle retire pulse
wb_busy  out  1  a write to wb_busy_rd is pending
wb_busy_rd  out  ADDR_W  pending destination
load_err  out  1  sticky error flag
commit_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE; waddr=0, wdata=0, reg_wen=0, commit=0, wb_busy=0, wb_busy_rd=0, load_err=0, commit_cnt=0, timeout counter=0.
- States: IDLE and WAIT_MEM. in_ready=1 only in IDLE. mem_rready=1 only in WAIT_MEM.
- All outputs except in_ready and mem_rready are registered.
- Accept: handshake when in_valid && in_ready. Latch rd, wen, result[1:0], ld_type.
- Non-load accept: next cycle reg_wen=in_wen && (in_rd!=0), waddr=in_rd, wdata=in_result, commit=1. State stays IDLE, so back-to-back accepts give one write per cycle.
- Load accept: go to WAIT_MEM and clear the counter.
- WAIT_MEM, cycle with mem_rvalid=1:
  - Next cycle write the extracted data with reg_wen=wen && rd!=0, commit=1.
  - Return to IDLE. mem_rdata is consumed only in WAIT_MEM; rvalid in IDLE is ignored.
- Extraction:
  - byte = mem_rdata >> (8*addr[1:0]); half = mem_rdata >> (16*addr[1]).
  - lb/lh sign-extend from bit 7/15. lbu/lhu zero-extend. lw passes the word.
- Errors (set load_err, sticky until reset):
  - lw with addr[1:0]!=0, or lh/lhu with addr[0]=1 → misaligned load.
  - ld_type 3, 6 or 7 → invalid type.
  - Either case: still wait for and drain mem_rvalid, then pulse commit=1 with reg_wen=0.
- Timeout: counter increments every WAIT_MEM cycle without rvalid. On reaching TIMEOUT: set load_err, return to IDLE, commit=0, reg_wen=0.
- wb_busy=1, wb_busy_rd=latched rd:
  - from the cycle after a load accept with wen && rd!=0, through the reg_wen cycle;
  - also during any reg_wen=1 cycle.
  - Otherwise wb_busy=0.
- reg_wen and commit are single-cycle pulses; both are 0 in every cycle without a retiring instruction.
- Async reset mid-WAIT_MEM aborts the load with no write and no commit.

Optional Feature:
Macro: YSYX_23060332_WBU_PERF_EN.
- Defined: commit_cnt increments by 1 on every commit pulse and wraps 0xFFFFFFFF→0.
- Not defined: the counter logic is absent and commit_cnt is tied to 0. The port list is identical in both builds.

Test Plan:
- Non-load: in_rd=5, in_wen=1, in_result=0x12345678 → next cycle reg_wen=1, waddr=5, wdata=0x12345678, commit=1; the following cycle both are 0.
- rd=0 write: in_rd=0, in_wen=1, result=0xFFFFFFFF → commit=1, reg_wen=0.
- Load sign extension:
  - lb, addr=0x80000003, mem_rdata=0x80FF7F01 after 3 wait cycles → wdata=0xFFFFFF80, reg_wen=1.
  - lbu, same stimulus → wdata=0x00000080.
  - During the wait: wb_busy=1, in_ready=0.
- Misaligned: lw, addr=0x80000002, rvalid after 1 cycle → load_err=1, commit=1, reg_wen=0; load_err stays 1 over the next 10 cycles.
- Timeout: lw with no mem_rvalid → after 255 WAIT_MEM cycles: load_err=1, return to IDLE, in_ready=1, no commit.
- Reset/perf: assert rst=0 mid-WAIT_MEM → all outputs 0 immediately. With PERF_EN, 4 back-to-back non-loads → commit_cnt=4.
